// File: rtl/sequential_divider_with_regs.sv
// Multi-cycle radix-2 restoring divider: registered operands, one quotient bit per cycle, packed {remainder, quotient} result.
// Optional macro SIGNED_DIV_EN: two's complement operands via magnitude/sign fix-up around the unsigned core.
module sequential_divider_with_regs #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [N-1:0]   inputA,
    input  logic [N-1:0]   inputB,
    output logic [2*N-1:0] result,
    output logic           valid,
    output logic           busy,
    output logic           div_by_zero
);
    // state | meaning
    // IDLE  | waiting for en; result and div_by_zero hold
    // RUN   | one quotient bit per cycle, counter N-1 down to 0
    // DONE  | load result register, pulse valid
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [N-1:0]  dvd_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  dsr_q;
    logic [N-1:0]  pr_q;
    logic [CW-1:0] cnt_q;
    logic          dbz_q;
    logic [N:0]    pr_shift;
    logic [N:0]    trial;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [N-1:0]  quo_fin;
    logic [N-1:0]  rem_fin;
    logic          load;
    logic          step;
    logic          finish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == '0) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Trial subtract is one bit wider so its MSB is the borrow.
    assign pr_shift = {pr_q, quo_q[N-1]};
    assign trial    = pr_shift - {1'b0, dsr_q};

`ifdef SIGNED_DIV_EN
    logic sign_a;
    logic sign_b;

    assign mag_a = inputA[N-1] ? -inputA : inputA;
    assign mag_b = inputB[N-1] ? -inputB : inputB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (load) begin
            sign_a <= inputA[N-1];
            sign_b <= inputB[N-1];
        end
    end

    // Most-negative / -1 falls out naturally: the magnitude quotient negates back to itself.
    always_comb begin
        quo_fin = (sign_a ^ sign_b) ? -quo_q : quo_q;
        rem_fin = sign_a ? -pr_q : pr_q;
        if (dbz_q) begin
            quo_fin = '1;
            rem_fin = dvd_q;
        end
    end
`else
    assign mag_a = inputA;
    assign mag_b = inputB;

    always_comb begin
        quo_fin = dbz_q ? '1 : quo_q;
        rem_fin = dbz_q ? dvd_q : pr_q;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            result      <= '0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                dvd_q <= inputA;
                quo_q <= mag_a;
                dsr_q <= mag_b;
                pr_q  <= '0;
                cnt_q <= CW'(N - 1);
                dbz_q <= (inputB == '0);
            end else if (step) begin
                pr_q  <= trial[N] ? pr_shift[N-1:0] : trial[N-1:0];
                quo_q <= {quo_q[N-2:0], ~trial[N]};
                if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end else if (finish) begin
                result      <= {rem_fin, quo_fin};
                valid       <= 1'b1;
                div_by_zero <= dbz_q;
            end
        end
    end
endmodule

// File: tb/tb_sequential_divider_with_regs.sv
// Self-checking bench for sequential_divider_with_regs: directed literal cases plus randomized traffic against a cycle-level model.
// Build with SIGNED_DIV_EN defined to also cover the signed variant.
module tb_sequential_divider_with_regs;
    localparam int N = 32;

    logic           clk    = 1'b0;
    logic           reset  = 1'b1;
    logic           en     = 1'b0;
    logic [N-1:0]   inputA = '0;
    logic [N-1:0]   inputB = '0;
    logic [2*N-1:0] result;
    logic           valid;
    logic           busy;
    logic           div_by_zero;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int m_load = -1;
    int valid_seen = 0;
    logic [2*N-1:0] exp_res = '0;
    logic [2*N-1:0] pend_res = '0;
    logic           exp_dbz = 1'b0;
    logic           pend_dbz = 1'b0;

    always #5 clk = ~clk;

    sequential_divider_with_regs #(.N(N)) dut (
        .clk(clk), .reset(reset), .en(en), .inputA(inputA), .inputB(inputB),
        .result(result), .valid(valid), .busy(busy), .div_by_zero(div_by_zero)
    );

    // Returns {div_by_zero, remainder, quotient} straight from the arithmetic definition.
    function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        logic signed [N-1:0] q;
        logic signed [N-1:0] r;
        sa = a;
        sb = b;
        if (b == '0) return {1'b1, a, {N{1'b1}}};
`ifdef SIGNED_DIV_EN
        if (a == {1'b1, {(N-1){1'b0}}} && b == {N{1'b1}}) return {1'b0, {N{1'b0}}, a};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
`else
        q = sa;
        r = sb;
        return {1'b0, a % b, a / b};
`endif
    endfunction

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Cycle-level model: one division accepted whenever the divider is idle, result lands N+1 edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_load  = -1;
            exp_res = '0;
            exp_dbz = 1'b0;
        end else begin
            edge_cnt++;
            if (m_load >= 0 && edge_cnt == m_load + N + 1) begin
                exp_res = pend_res;
                exp_dbz = pend_dbz;
            end
            if (en && (m_load < 0 || edge_cnt >= m_load + N + 2)) begin
                {pend_dbz, pend_res} = model(inputA, inputB);
                m_load = edge_cnt;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_valid;
        logic exp_busy;
        exp_valid = !reset && m_load >= 0 && edge_cnt == m_load + N + 1;
        exp_busy  = !reset && m_load >= 0 && edge_cnt >= m_load && edge_cnt <= m_load + N;
        chk("valid", {63'd0, valid}, {63'd0, exp_valid});
        chk("busy", {63'd0, busy}, {63'd0, exp_busy});
        chk("result", result, exp_res);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dbz});
        if (valid) valid_seen++;
    end

    task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, output int load_edge);
        @(negedge clk);
        en = 1'b1; inputA = a; inputB = b;
        @(negedge clk);
        en = 1'b0; inputA = $urandom; inputB = $urandom;
        load_edge = edge_cnt;
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (valid) begin
                at = edge_cnt;
                break;
            end
        end
        #1;
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL wait_valid: got no pulse expected valid within %0d cycles", 3 * N);
        end
    endtask

    function automatic logic [N-1:0] rand_divisor(input logic [N-1:0] a);
        case ($urandom_range(0, 4))
            0: return '0;
            1: return N'($urandom_range(1, 15));
            2: return a >> $urandom_range(0, N - 1);
            3: return {N{1'b1}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ld, at, at2, vs;
        logic [N-1:0] ra;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_result", result, '0);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        #1 reset = 1'b0;

        start(100, 7, ld);
        #1 chk("busy_rise", {63'd0, busy}, 64'd1);
        wait_valid(at);
        chk("latency", 64'(at - ld), 64'd33);
        chk("basic_res", result, {32'd2, 32'd14});
        chk("basic_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk) #1 chk("valid_one_cycle", {63'd0, valid}, 64'd0);

        start(32'hFFFF_FFFF, 1, ld); wait_valid(at);
        chk("max_div_1", result, {32'd0, 32'hFFFF_FFFF});
        start(5, 9, ld); wait_valid(at);
        chk("small_div_big", result, {32'd5, 32'd0});

        start(5, 0, ld); wait_valid(at);
        chk("dbz_res", result, {32'd5, 32'hFFFF_FFFF});
        chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        start(10, 3, ld); wait_valid(at);
        chk("dbz_clear_res", result, {32'd1, 32'd3});
        chk("dbz_clear_flag", {63'd0, div_by_zero}, 64'd0);

        vs = valid_seen;
        start(50, 5, ld);
        repeat (8) @(negedge clk);
        en = 1'b1; inputA = 77; inputB = 3;
        @(negedge clk); en = 1'b0;
        wait_valid(at);
        chk("busy_ignore_res", result, {32'd0, 32'd10});
        repeat (2 * N) @(negedge clk);
        chk("busy_ignore_count", 64'(valid_seen - vs), 64'd1);

        start(20, 6, ld); wait_valid(at);
        en = 1'b1; inputA = 9; inputB = 2;
        @(negedge clk); en = 1'b0;
        wait_valid(at2);
        chk("b2b_spacing", 64'(at2 - at), 64'd34);
        chk("b2b_res", result, {32'd1, 32'd4});

        start(1000, 3, ld);
        repeat (13) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_result", result, '0);
        chk("rst_mid_valid", {63'd0, valid}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        @(negedge clk) #2 reset = 1'b0;
        vs = valid_seen;
        repeat (3 * N) @(negedge clk);
        chk("rst_no_late_valid", 64'(valid_seen - vs), 64'd0);
        start(1000, 3, ld); wait_valid(at);
        chk("after_rst_res", result, {32'd1, 32'd333});

`ifdef SIGNED_DIV_EN
        start(-32'sd7, 2, ld); wait_valid(at);
        chk("s_neg_dvd", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        start(7, -32'sd2, ld); wait_valid(at);
        chk("s_neg_dsr", result, {32'd1, 32'hFFFF_FFFD});
        start(32'h8000_0000, 32'hFFFF_FFFF, ld); wait_valid(at);
        chk("s_overflow", result, {32'd0, 32'h8000_0000});
        chk("s_overflow_flag", {63'd0, div_by_zero}, 64'd0);
`endif

        // Random traffic: en requests at random, including while busy and in valid cycles.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ra = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : N'($urandom);
            en = ($urandom_range(0, 3) == 0);
            inputA = ra;
            inputB = rand_divisor(ra);
        end
        @(negedge clk) en = 1'b0;
        repeat (2 * N + 4) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sequential_divider_with_regs.md
Name: sequential_divider_with_regs

Overview:
- Multi-cycle radix-2 restoring divider, the inverse-operation counterpart of the team's sequential Booth multiplier.
- Registered operand inputs, an internal FSM that produces one quotient bit per cycle, and a registered packed result {remainder, quotient}.
- Sits beside the multiplier in the arithmetic datapath and uses the same load-enable / output-enable style.

Parameters:
- N, 32, operand width in bits. Dividend, divisor, quotient and remainder are all N bits. N must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  start request; sampled only in IDLE
- inputA  input  N  dividend
- inputB  input  N  divisor
- result  output  2N  {remainder[N-1:0], quotient[N-1:0]}; remainder in the upper half
- valid  output  1  one-cycle pulse when result updates
- busy  output  1  high in RUN and DONE
- div_by_zero  output  1  registered flag for the current result; divisor was 0

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - state goes to IDLE
  - result = 0, valid = 0, busy = 0, div_by_zero = 0
  - operand, partial-remainder and counter registers cleared
  - any in-flight division is discarded
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If en = 1 at an edge: capture inputA and inputB, clear the partial remainder, set counter = N-1, go to RUN.
  - If en = 0: hold. result and div_by_zero keep their last values.
- RUN, one iteration per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtract: PR - divisor, computed N+1 bits wide.
  - If the difference is non-negative, PR takes the difference and the quotient LSB is 1; otherwise PR is kept and the quotient LSB is 0.
  - After the iteration with counter = 0, go to DONE; otherwise decrement the counter.
- DONE: load the result register, set valid = 1 for exactly this one edge's output cycle, go to IDLE.
- Latency:
  - Load edge is edge 0. Result and valid appear after edge N+1 (33 cycles for N=32).
  - valid is high in the first IDLE cycle after DONE.
- Back-to-back: en high during the valid cycle is accepted (the state is IDLE). Sustained throughput is one result per N+2 cycles.
- en while busy = 1 is ignored. Changes on inputA/inputB while busy have no effect.
- Divide by zero:
  - Detected at the load edge.
  - The divider still runs the full N cycles, so latency is unchanged.
  - Forced output: quotient = all ones, remainder = dividend, div_by_zero = 1 alongside valid.
- div_by_zero is updated only when result is loaded.
- Arithmetic is unsigned. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- When defined, operands are two's complement:
  - Load stage takes the magnitudes of both operands and records the sign of each.
  - Unsigned core runs unchanged.
  - DONE stage negates the quotient when the operand signs differ, and negates the remainder when the dividend is negative. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow case, most-negative dividend / -1: quotient = most-negative value, remainder = 0, no flag.
  - Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero = 1.
  - Latency is unchanged at N+1 cycles.
- When undefined: unsigned only, and no sign logic is synthesized.

Test Plan:
- Basic: N=32, load 100 / 7 with en for 1 cycle -> busy rises; after 33 cycles valid pulses for 1 cycle; result = {32'd2, 32'd14}; div_by_zero = 0.
- Extremes: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0. Then 5 / 9 -> quotient 0, remainder 5.
- Divide by zero: 5 / 0 -> after 33 cycles, result = {32'd5, 32'hFFFFFFFF}, div_by_zero = 1. Next 10 / 3 clears the flag.
- Busy/back-to-back:
  - Pulse en with 50 / 5 again at cycle 10 while busy -> ignored; single valid with {0, 10}.
  - en held during the valid cycle with 9 / 2 -> second valid exactly 34 cycles after the first; result {1, 4}.
- Reset mid-op: start 1000 / 3, assert reset at cycle 15 -> result = 0, valid = 0, busy = 0 immediately, with no later valid. Then 1000 / 3 -> {1, 333}.
- SIGNED_DIV_EN builds only:
  - -7 / 2 -> quotient -3 (0xFFFFFFFD), remainder -1.
  - 7 / -2 -> quotient -3, remainder 1.
  - 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
